// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: loads a program over AXI-Stream into local imem, then issues one instruction per cycle to the decoder.
// Latency: instr/pc/instr_valid are registered 1 cycle after fetch_pc; a taken branch costs one bubble cycle.
// Backpressure: s_axis_tready low in RUN/FLUSH; stall_in freezes fetch. Optional macro IFU_PERF_CNT_EN adds perf counters.
module inst_fetch_unit #(
    parameter int DWIDTH_INST = 32,
    parameter int IMEM_DEPTH  = 256,
    parameter int PC_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DWIDTH_INST-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    input  logic                   start,
    input  logic                   stall_in,
    input  logic                   branch_taken,
    input  logic [11:0]            branch_offset,
    output logic [DWIDTH_INST-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_W-1:0]        pc,
    output logic                   busy,
    output logic                   done,
    output logic                   load_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

    localparam logic [PC_W:0] DEPTH = (PC_W+1)'(IMEM_DEPTH);

    state_t state, state_nxt;

    logic [DWIDTH_INST-1:0] imem [IMEM_DEPTH];

    // One extra bit so pointers and lengths can hold the full IMEM_DEPTH
    logic [PC_W:0]   wr_ptr, fetch_pc, prog_len;
    logic [PC_W-1:0] wr_addr, target;
    logic            beat, wr_en, take_branch, in_range, fetch, finish;
    logic            unused_bit;

    assign beat        = s_axis_tvalid && s_axis_tready;
    assign take_branch = (state == RUN) && !stall_in && instr_valid && branch_taken;
    assign in_range    = fetch_pc < prog_len;
    assign target      = pc + PC_W'(signed'(branch_offset[11:1]));
    assign unused_bit  = branch_offset[0];
    assign wr_addr     = (state == IDLE) ? '0 : wr_ptr[PC_W-1:0];
    assign wr_en       = beat && ((state == IDLE) || ((state == LOAD) && (wr_ptr < DEPTH)));
    assign busy        = (state == RUN) || (state == FLUSH);

    assign fetch  = ((state == RUN) && !stall_in && !take_branch && in_range) ||
                    ((state == FLUSH) && in_range);
    assign finish = ((state == RUN) && !stall_in && !take_branch && !in_range) ||
                    ((state == FLUSH) && !in_range);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat)                          state_nxt = s_axis_tlast ? IDLE : LOAD;
                else if (start && prog_len != '0)  state_nxt = RUN;
            end
            LOAD:  if (beat && s_axis_tlast) state_nxt = IDLE;
            RUN: begin
                if (take_branch)                   state_nxt = FLUSH;
                else if (!stall_in && !in_range)   state_nxt = IDLE;
            end
            FLUSH: state_nxt = in_range ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Program memory is deliberately left untouched by rst
    always_ff @(posedge clk) begin
        if (wr_en) imem[wr_addr] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            fetch_pc      <= '0;
            prog_len      <= '0;
            wr_ptr        <= '0;
            pc            <= '0;
            instr         <= '0;
            instr_valid   <= 1'b0;
            done          <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            s_axis_tready <= (state_nxt == IDLE) || (state_nxt == LOAD);
            done          <= finish;

            if ((state == IDLE) && (state_nxt == RUN)) fetch_pc <= '0;
            else if (take_branch)                      fetch_pc <= {1'b0, target};
            else if (fetch)                            fetch_pc <= fetch_pc + 1'b1;

            if (fetch) begin
                instr       <= imem[fetch_pc[PC_W-1:0]];
                pc          <= fetch_pc[PC_W-1:0];
                instr_valid <= 1'b1;
            end else if (take_branch || finish) begin
                instr_valid <= 1'b0;
            end

            if (beat && (state == IDLE)) begin
                wr_ptr   <= {{PC_W{1'b0}}, 1'b1};
                load_err <= 1'b0;
                if (s_axis_tlast) prog_len <= {{PC_W{1'b0}}, 1'b1};
            end else if (beat && (state == LOAD)) begin
                if (wr_ptr < DEPTH) wr_ptr   <= wr_ptr + 1'b1;
                else                load_err <= 1'b1;
                if (s_axis_tlast) prog_len <= (wr_ptr < DEPTH) ? wr_ptr + 1'b1 : DEPTH;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && (state_nxt == RUN))) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
            if ((state == RUN) && stall_in && instr_valid && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: cycle tables for the directed cases, random runs checked by retirement order.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam int DW = 32;
    localparam int DEPTH = 256;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          start, stall_in, branch_taken;
    logic [11:0]   branch_offset;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          busy, done, load_err;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(.DWIDTH_INST(DW), .IMEM_DEPTH(DEPTH), .PC_W(PW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .start(start), .stall_in(stall_in), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done), .load_err(load_err)
`ifdef IFU_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] prog [0:299];

    typedef struct {
        int          scen;
        logic        stall;
        logic        br;
        logic [11:0] off;
        logic        e_vld;
        int          e_pc;
        logic        e_done;
        logic        e_busy;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int s, input logic st, input logic b, input logic [11:0] o,
                                input logic v, input int p, input logic d, input logic bz);
        vec_t x;
        x.scen = s; x.stall = st; x.br = b; x.off = o;
        x.e_vld = v; x.e_pc = p; x.e_done = d; x.e_busy = bz;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic load_prog(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = prog[i];
            s_axis_tlast  = (i == n - 1);
            for (int t = 0; t < 20 && !s_axis_tready; t++) @(negedge clk);
            if (!s_axis_tready) chk("load_tready", s_axis_tready, 1);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_scen(input int s);
        int j;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        foreach (vecs[k]) begin
            if (vecs[k].scen == s) begin
                chk($sformatf("s%0d_j%0d_vld", s, j), instr_valid, vecs[k].e_vld);
                if (vecs[k].e_vld) begin
                    chk($sformatf("s%0d_j%0d_pc", s, j), pc, vecs[k].e_pc);
                    chk($sformatf("s%0d_j%0d_instr", s, j), instr, prog[vecs[k].e_pc]);
                end
                chk($sformatf("s%0d_j%0d_done", s, j), done, vecs[k].e_done);
                chk($sformatf("s%0d_j%0d_busy", s, j), busy, vecs[k].e_busy);
                stall_in      = vecs[k].stall;
                branch_taken  = vecs[k].br;
                branch_offset = vecs[k].off;
                @(negedge clk);
                j++;
            end
        end
        stall_in = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    endtask

    // Reference: retirement order follows pc+1, or pc+word_offset mod 256 on a taken branch;
    // leaving [0,L) ends the program, with one extra bubble cycle when the exit was a branch.
    task automatic rand_runs(input int runs);
        for (int r = 0; r < runs; r++) begin
            int L, exp_pc, done_at, retired, woff, nxt;
            bit ok;
            L = $urandom_range(1, 16);
            for (int i = 0; i < L; i++) prog[i] = $urandom;
            load_prog(L, 1'b1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            exp_pc = 0; done_at = -1; retired = 0; ok = 1'b0;
            for (int cyc = 0; cyc < 400 && !ok; cyc++) begin
                if (done_at >= 0 && cyc == done_at) begin
                    chk($sformatf("rnd%0d_done", r), done, 1);
                    ok = 1'b1;
                end else begin
                    chk($sformatf("rnd%0d_done_early", r), done, 0);
                    if (done_at >= 0) chk($sformatf("rnd%0d_vld_after_end", r), instr_valid, 0);
                end
                stall_in = 1'b0; branch_taken = 1'b0; branch_offset = 12'($urandom);
                if (done_at < 0 && !ok) begin
                    stall_in      = ($urandom_range(0, 3) == 0);
                    branch_taken  = (retired < 40) && ($urandom_range(0, 3) == 0);
                    woff          = $urandom_range(0, 12) - 6;
                    branch_offset = {11'(woff), 1'($urandom_range(0, 1))};
                    if (instr_valid && !stall_in) begin
                        chk($sformatf("rnd%0d_pc", r), pc, exp_pc);
                        chk($sformatf("rnd%0d_instr", r), instr, prog[exp_pc]);
                        retired++;
                        nxt = branch_taken ? ((exp_pc + woff) & 255) : exp_pc + 1;
                        if (nxt >= L) done_at = cyc + (branch_taken ? 2 : 1);
                        exp_pc = nxt;
                    end
                end
                @(negedge clk);
            end
            chk($sformatf("rnd%0d_finished", r), ok, 1);
            stall_in = 1'b0; branch_taken = 1'b0;
        end
    endtask

    initial begin
        int k;
        bit seen_done;

        // scen 1: plain 4-word run; a branch while instr_valid=0 must be ignored
        add(1, 0, 1, 12'h7FE, 0, -1, 0, 1);
        for (int p = 0; p < 4; p++) add(1, 0, 0, 12'h000, 1, p, 0, 1);
        add(1, 0, 0, 12'h000, 0, -1, 1, 0);
        add(1, 0, 0, 12'h000, 0, -1, 0, 0);
        // scen 2: 3-cycle stall on A1
        add(2, 0, 0, 12'h000, 0, -1, 0, 1);
        add(2, 0, 0, 12'h000, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(2, 1, 0, 12'h000, 1, 1, 0, 1);
        add(2, 0, 0, 12'h000, 1, 1, 0, 1);
        add(2, 0, 0, 12'h000, 1, 2, 0, 1);
        add(2, 0, 0, 12'h000, 1, 3, 0, 1);
        add(2, 0, 0, 12'h000, 0, -1, 1, 0);
        add(2, 0, 0, 12'h000, 0, -1, 0, 0);
        // scen 3: backward branch -3 at pc=5
        add(3, 0, 0, 12'h000, 0, -1, 0, 1);
        for (int p = 0; p < 5; p++) add(3, 0, 0, 12'h000, 1, p, 0, 1);
        add(3, 0, 1, 12'hFFA, 1, 5, 0, 1);
        add(3, 0, 0, 12'h000, 0, -1, 0, 1);
        for (int p = 2; p < 8; p++) add(3, 0, 0, 12'h000, 1, p, 0, 1);
        add(3, 0, 0, 12'h000, 0, -1, 1, 0);
        add(3, 0, 0, 12'h000, 0, -1, 0, 0);
        // scen 4: forward branch beyond prog_len
        add(4, 0, 0, 12'h000, 0, -1, 0, 1);
        add(4, 0, 0, 12'h000, 1, 0, 0, 1);
        add(4, 0, 1, 12'h010, 1, 1, 0, 1);
        add(4, 0, 0, 12'h000, 0, -1, 0, 1);
        add(4, 0, 0, 12'h000, 0, -1, 1, 0);
        add(4, 0, 0, 12'h000, 0, -1, 0, 0);

        rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        start = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_tready", s_axis_tready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", s_axis_tready, 1);

        for (int i = 0; i < 4; i++) prog[i] = 32'hA000_0000 + i;
        load_prog(4, 1'b1);
        run_scen(1);
        run_scen(2);
`ifdef IFU_PERF_CNT_EN
        chk("perf_stalls", perf_stalls, 3);
        chk("perf_cycles", perf_cycles, 8);
`endif

        for (int i = 0; i < 8; i++) prog[i] = 32'hB000_0000 + (i * 16'h1111);
        load_prog(8, 1'b0);
        run_scen(3);
        run_scen(4);

        // overflow: 258 beats, only 256 kept
        for (int i = 0; i < DEPTH + 2; i++) prog[i] = 32'hC000_0000 + i;
        load_prog(DEPTH + 2, 1'b0);
        chk("ovf_load_err", load_err, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; seen_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (instr_valid) begin
                chk($sformatf("ovf_pc%0d", k), pc, k);
                chk($sformatf("ovf_instr%0d", k), instr, prog[k]);
                k++;
            end
            seen_done = done;
            @(negedge clk);
        end
        chk("ovf_done_seen", seen_done, 1);
        chk("ovf_count", k, DEPTH);
        chk("ovf_last_pc", pc, DEPTH - 1);

        // reload clears load_err; then reset mid-run at pc=2
        for (int i = 0; i < 4; i++) prog[i] = 32'hA000_0000 + i;
        load_prog(4, 1'b0);
        chk("reload_load_err", load_err, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_pc_before_rst", pc, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", instr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_tready", s_axis_tready, 0);
        rst = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("norun_busy%0d", i), busy, 0);
            chk($sformatf("norun_vld%0d", i), instr_valid, 0);
        end
        chk("norun_tready", s_axis_tready, 1);
        start = 1'b0;

        rand_runs(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction sequencer that sits directly upstream of the ISA decoder.
- Receives a program over AXI-Stream into a local instruction memory, then fetches one 32-bit instruction per cycle onto the decoder's `instr` input.
- Holds on stall from the vector execute path and redirects the PC on a taken beq.
- Reports busy and done to the CGRA control plane.

Parameters:
- DWIDTH_INST, 32, instruction width (matches decoder input).
- IMEM_DEPTH, 256, instruction memory depth in words.
- PC_W, 8, PC width in words; must equal clog2(IMEM_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tdata  in  DWIDTH_INST  program word
- s_axis_tvalid  in  1  program word valid
- s_axis_tlast  in  1  last program word
- s_axis_tready  out  1  ready to accept a program word
- start  in  1  level; begin executing the loaded program
- stall_in  in  1  execute busy (vector op in flight); freeze fetch
- branch_taken  in  1  beq in the current instr resolved taken
- branch_offset  in  12  decoder branch_immediate = imm[12:1]
- instr  out  DWIDTH_INST  instruction to the decoder
- instr_valid  out  1  instr holds a live instruction
- pc  out  PC_W  word address of the current instr
- busy  out  1  state is RUN or FLUSH
- done  out  1  one-cycle pulse at program end
- load_err  out  1  sticky; program overflowed IMEM_DEPTH

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, prog_len=0, fetch_pc=0, pc=0, instr=0, instr_valid=0, busy=0, done=0, load_err=0, s_axis_tready=0 for one cycle after rst (then 1 in IDLE).
- Instruction memory contents are not cleared by rst.

States:
- IDLE
  - s_axis_tready=1.
  - An accepted beat writes imem[0], sets wr_ptr=1, and moves to LOAD.
  - Else, if start and prog_len!=0, moves to RUN with fetch_pc=0.
  - s_axis_tvalid and start in the same cycle: load wins.
- LOAD
  - s_axis_tready=1.
  - Each accepted beat writes imem[wr_ptr], and wr_ptr increments.
  - Beats with wr_ptr>=IMEM_DEPTH are dropped and set load_err.
  - On the accepted tlast beat: prog_len=min(beats, IMEM_DEPTH), return to IDLE.
- RUN
  - Synchronous imem read, 1-cycle latency: instr/pc/instr_valid are registered the cycle after fetch_pc is presented.
  - When stall_in=0, fetch_pc increments each cycle.
  - When stall_in=1: fetch_pc, instr, pc and instr_valid all hold; the same instruction is re-presented.
  - branch_taken is sampled only when instr_valid=1 and stall_in=0.
  - On a taken branch, target = pc + sext(branch_offset[11:1]), modulo 2^PC_W.
  - Taken branch: fetch_pc=target, the in-flight fetch is discarded, and the state moves to FLUSH.
  - When fetch_pc reaches prog_len, no further fetch is issued. After the last instr retires (instr_valid && !stall_in), instr_valid drops, done pulses 1 cycle, and the state returns to IDLE.
- FLUSH
  - instr_valid=0 for exactly one cycle (one bubble) while the target is read.
  - Then RUN, presenting imem[target].
  - A target >= prog_len ends the program as above.
- Other rules:
  - s_axis_tready=0 in RUN and FLUSH.
  - Deasserting start mid-RUN has no effect; only rst aborts.
  - rst mid-RUN/LOAD returns to IDLE immediately. prog_len=0, so the program must be reloaded.
  - load_err clears only on rst or on the first beat of a new load.
  - instr holds its last value while instr_valid=0.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds two outputs: perf_cycles (32) and perf_stalls (32).
  - Both clear on the IDLE->RUN transition.
  - perf_cycles increments every cycle in RUN or FLUSH.
  - perf_stalls increments every RUN cycle with stall_in=1 and instr_valid=1.
  - Both saturate at 2^32-1 and hold their value after done until the next start.
- When undefined, the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Load 4 words A0..A3 (tlast on A3), then start=1 -> instr=A0,A1,A2,A3 on consecutive cycles; first instr_valid 2 cycles after start; pc=0..3; done pulse the cycle after A3; busy=0 afterwards.
- Same program, stall_in=1 for 3 cycles while instr=A1 -> A1 held with pc=1 for 4 cycles total, then A2; done delayed by 3 cycles; with IFU_PERF_CNT_EN, perf_stalls=3.
- 8-word program, branch_taken=1 at pc=5 with branch_offset=12'hFFA (word offset -3) -> one bubble, then pc=2,3,4,5; second pass at pc=5 with branch_taken=0 -> 6,7, then done.
- Branch at pc=1 with branch_offset=12'h010 (word +8, target 9 >= prog_len=8) -> one bubble, then done with no further instr_valid.
- Stream IMEM_DEPTH+2 beats -> load_err=1, prog_len=256; start executes 256 words, pc wraps never.
- rst asserted while in RUN at pc=2 -> next cycle instr_valid=0, busy=0, pc=0; start ignored until a reload (prog_len=0).
